// File: rtl/rf_issue_stage.sv
// rf_issue_stage: register file read + 2-entry skid toward the ALU.
// Build option: RF_CLEAR_ON_RESET_EN clears registers on reset.
module rf_issue_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] raddr1,
  input  logic [ADDR_WIDTH-1:0] raddr2,
  input  logic [2:0]            req_aluop,
  input  logic                  wen,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] A,
  output logic [DATA_WIDTH-1:0] B,
  output logic [2:0]            ALUop
);

  localparam int NREG = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {
    S_EMPTY,
    S_ONE,
    S_TWO
  } state_t;

  state_t state;
  state_t state_nx;

  logic [DATA_WIDTH-1:0] regs [NREG];
  logic [DATA_WIDTH-1:0] rd1;
  logic [DATA_WIDTH-1:0] rd2;
  logic [DATA_WIDTH-1:0] skid_a;
  logic [DATA_WIDTH-1:0] skid_b;
  logic [2:0]            skid_op;
  logic                  ready_q;
  logic                  accept;
  logic                  consume;
  logic                  load_out;
  logic                  load_skid;
  logic                  move_skid;

  assign req_ready = ready_q;
  assign out_valid = (state != S_EMPTY);
  assign accept    = req_valid & ready_q;
  assign consume   = out_valid & out_ready;

  // Operand A read: r0 is zero, same-cycle write is forwarded
  always_comb begin
    rd1 = regs[raddr1];
    if (raddr1 == '0)
      rd1 = '0;
    else if (wen && (waddr == raddr1))
      rd1 = wdata;
  end

  // Operand B read: r0 is zero, same-cycle write is forwarded
  always_comb begin
    rd2 = regs[raddr2];
    if (raddr2 == '0)
      rd2 = '0;
    else if (wen && (waddr == raddr2))
      rd2 = wdata;
  end

`ifdef RF_CLEAR_ON_RESET_EN
  // Register file write; contents cleared by reset
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NREG; i++)
        regs[i] <= '0;
    end else if (wen && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end
`else
  // Register file write; contents survive reset
  always_ff @(posedge clk) begin
    if (wen && (waddr != '0))
      regs[waddr] <= wdata;
  end
`endif

  // FIFO occupancy register and registered ready
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= S_EMPTY;
      ready_q <= 1'b1;
    end else begin
      state   <= state_nx;
      ready_q <= (state_nx != S_TWO);
    end
  end

  // Next occupancy from accept/consume
  always_comb begin
    state_nx = state;
    unique case (state)
      S_EMPTY: if (accept) state_nx = S_ONE;
      S_ONE: begin
        if (accept && !consume)
          state_nx = S_TWO;
        else if (!accept && consume)
          state_nx = S_EMPTY;
      end
      S_TWO: if (consume) state_nx = S_ONE;
      default: state_nx = S_EMPTY;
    endcase
  end

  // Datapath steering per occupancy
  always_comb begin
    load_out  = 1'b0;
    load_skid = 1'b0;
    move_skid = 1'b0;
    unique case (state)
      S_EMPTY: load_out = accept;
      S_ONE: begin
        load_out  = accept & consume;
        load_skid = accept & ~consume;
      end
      S_TWO: move_skid = consume;
      default: ;
    endcase
  end

  // Output and skid operand registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      A       <= '0;
      B       <= '0;
      ALUop   <= '0;
      skid_a  <= '0;
      skid_b  <= '0;
      skid_op <= '0;
    end else begin
      if (load_out) begin
        A     <= rd1;
        B     <= rd2;
        ALUop <= req_aluop;
      end else if (move_skid) begin
        A     <= skid_a;
        B     <= skid_b;
        ALUop <= skid_op;
      end
      if (load_skid) begin
        skid_a  <= rd1;
        skid_b  <= rd2;
        skid_op <= req_aluop;
      end
    end
  end

endmodule

// File: tb/tb_rf_issue_stage.sv
// tb_rf_issue_stage: randomized bench with a queue-based model.
// Honours RF_CLEAR_ON_RESET_EN for post-reset register contents.
module tb_rf_issue_stage;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [4:0]  raddr1 = '0;
  logic [4:0]  raddr2 = '0;
  logic [2:0]  req_aluop = '0;
  logic        wen = 1'b0;
  logic [4:0]  waddr = '0;
  logic [31:0] wdata = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] A;
  logic [31:0] B;
  logic [2:0]  ALUop;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
  } ent_t;

  ent_t        q[$];
  logic [31:0] mreg [32];

  always #5 clk = ~clk;

  rf_issue_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready),
    .raddr1(raddr1), .raddr2(raddr2), .req_aluop(req_aluop),
    .wen(wen), .waddr(waddr), .wdata(wdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .A(A), .B(B), .ALUop(ALUop)
  );

  function automatic logic [31:0] rd(input logic [4:0] ra);
    if (ra == 5'd0) return 32'd0;
    if (wen && waddr == ra) return wdata;
    return mreg[ra];
  endfunction

  // Advance one clock, updating the model from the inputs now applied.
  task automatic tick();
    ent_t e;
    ent_t d;
    bit acc;
    bit cons;
    acc  = req_valid && (q.size() < 2);
    cons = out_ready && (q.size() > 0);
    e = '{rd(raddr1), rd(raddr2), req_aluop};
    if (cons) d = q.pop_front();
    if (acc) q.push_back(e);
    if (wen && waddr != 5'd0) mreg[waddr] = wdata;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    req_valid = 1'b0;
    wen = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic model_reset();
    q.delete();
`ifdef RF_CLEAR_ON_RESET_EN
    for (int i = 0; i < 32; i++) mreg[i] = 32'd0;
`endif
    mreg[0] = 32'd0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 32; i++) mreg[i] = 'x;
    idle();
    #1 resetn = 1'b0;
    #1;
    model_reset();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", out_valid); end
    checks++; if ({A, B, ALUop} !== 67'd0) begin errors++; $display("FAIL reset_data got=%h/%h/%0d exp=0", A, B, ALUop); end
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%0b exp=1", req_ready); end
  endtask

  task automatic test_basic();
    wen = 1'b1; waddr = 5'd5; wdata = 32'h0000_00FF;
    tick();
    wen = 1'b0;
    req_valid = 1'b1; raddr1 = 5'd5; raddr2 = 5'd0; req_aluop = 3'b010;
    tick();
    req_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got=%0b exp=1", out_valid); end
    checks++; if (A !== 32'h0000_00FF) begin errors++; $display("FAIL basic_a got=%h exp=000000ff", A); end
    checks++; if (B !== 32'd0) begin errors++; $display("FAIL basic_b got=%h exp=0", B); end
    checks++; if (ALUop !== 3'b010) begin errors++; $display("FAIL basic_op got=%b exp=010", ALUop); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_drain got=%0b exp=0", out_valid); end
  endtask

  task automatic test_r0();
    wen = 1'b1; waddr = 5'd0; wdata = 32'hDEAD_BEEF;
    tick();
    wen = 1'b0;
    req_valid = 1'b1; raddr1 = 5'd0; raddr2 = 5'd5; req_aluop = 3'd3;
    tick();
    req_valid = 1'b0;
    checks++; if (A !== 32'd0) begin errors++; $display("FAIL r0_a got=%h exp=0", A); end
    checks++; if (B !== 32'h0000_00FF) begin errors++; $display("FAIL r0_b got=%h exp=000000ff", B); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_bypass();
    wen = 1'b1; waddr = 5'd7; wdata = 32'h1234_5678;
    req_valid = 1'b1; raddr1 = 5'd5; raddr2 = 5'd7; req_aluop = 3'd5;
    tick();
    req_valid = 1'b0;
    wen = 1'b1; waddr = 5'd7; wdata = 32'hCAFE_F00D;
    tick();
    wen = 1'b0;
    checks++; if (B !== 32'h1234_5678) begin errors++; $display("FAIL bypass_b got=%h exp=12345678", B); end
    checks++; if (ALUop !== 3'd5) begin errors++; $display("FAIL bypass_op got=%0d exp=5", ALUop); end
    out_ready = 1'b1;
    req_valid = 1'b1; raddr1 = 5'd0; raddr2 = 5'd7; req_aluop = 3'd1;
    tick();
    req_valid = 1'b0;
    checks++; if (B !== 32'hCAFE_F00D) begin errors++; $display("FAIL bypass_new got=%h exp=cafef00d", B); end
    checks++; if (ALUop !== 3'd1) begin errors++; $display("FAIL bypass_newop got=%0d exp=1", ALUop); end
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    wen = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      waddr = 5'(i); wdata = 32'(i * 11);
      tick();
    end
    wen = 1'b0;
    out_ready = 1'b0;
    req_valid = 1'b1; raddr2 = 5'd0;
    raddr1 = 5'd1; req_aluop = 3'd1;
    tick();
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL bp_ready1 got=%0b exp=1", req_ready); end
    checks++; if (A !== 32'd11) begin errors++; $display("FAIL bp_a1 got=%0d exp=11", A); end
    raddr1 = 5'd2; req_aluop = 3'd2;
    tick();
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_ready2 got=%0b exp=0", req_ready); end
    checks++; if (A !== 32'd11) begin errors++; $display("FAIL bp_hold got=%0d exp=11", A); end
    raddr1 = 5'd3; req_aluop = 3'd3;
    tick();
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_ready3 got=%0b exp=0", req_ready); end
    checks++; if ({A, ALUop} !== {32'd11, 3'd1}) begin errors++; $display("FAIL bp_stable got=%0d/%0d exp=11/1", A, ALUop); end
    out_ready = 1'b1;
    tick();
    checks++; if ({out_valid, A, ALUop} !== {1'b1, 32'd22, 3'd2}) begin errors++; $display("FAIL bp_second got=%0b/%0d/%0d exp=1/22/2", out_valid, A, ALUop); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL bp_reopen got=%0b exp=1", req_ready); end
    tick();
    req_valid = 1'b0;
    checks++; if ({out_valid, A, ALUop} !== {1'b1, 32'd33, 3'd3}) begin errors++; $display("FAIL bp_third got=%0b/%0d/%0d exp=1/33/3", out_valid, A, ALUop); end
    tick();
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got=%0b exp=0", out_valid); end
  endtask

  task automatic test_fill();
    wen = 1'b1;
    for (int i = 1; i < 32; i++) begin
      waddr = 5'(i); wdata = $urandom;
      tick();
    end
    wen = 1'b0;
  endtask

  task automatic test_streaming();
    req_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      raddr1 = 5'($urandom); raddr2 = 5'($urandom); req_aluop = 3'($urandom);
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL stream_ready i=%0d got=%0b exp=1", i, req_ready); end
      if (i > 0) begin
        checks++;
        if ({out_valid, A, B, ALUop} !== {1'b1, q[0].a, q[0].b, q[0].op}) begin
          errors++;
          $display("FAIL stream_data i=%0d got=%0b/%h/%h/%0d exp=1/%h/%h/%0d", i, out_valid, A, B, ALUop, q[0].a, q[0].b, q[0].op);
        end
      end
      tick();
    end
    req_valid = 1'b0;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      req_valid = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 2) != 0);
      raddr1 = 5'($urandom); raddr2 = 5'($urandom); req_aluop = 3'($urandom);
      wen = ($urandom_range(0, 2) == 0);
      waddr = 5'($urandom); wdata = $urandom;
      checks++; if (out_valid !== (q.size() > 0)) begin errors++; $display("FAIL rand_valid i=%0d got=%0b exp=%0b", i, out_valid, q.size() > 0); end
      checks++; if (req_ready !== (q.size() < 2)) begin errors++; $display("FAIL rand_ready i=%0d got=%0b exp=%0b", i, req_ready, q.size() < 2); end
      if (q.size() > 0) begin
        checks++;
        if ({A, B, ALUop} !== {q[0].a, q[0].b, q[0].op}) begin
          errors++;
          $display("FAIL rand_data i=%0d got=%h/%h/%0d exp=%h/%h/%0d", i, A, B, ALUop, q[0].a, q[0].b, q[0].op);
        end
      end
      tick();
    end
    idle();
    out_ready = 1'b1;
    tick();
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    idle();
    wen = 1'b1; waddr = 5'd5; wdata = 32'h0000_00FF;
    tick();
    wen = 1'b0;
    req_valid = 1'b1; raddr1 = 5'd5; raddr2 = 5'd5; req_aluop = 3'd6;
    tick();
    tick();
    req_valid = 1'b0;
    checks++; if ({out_valid, req_ready} !== 2'b10) begin errors++; $display("FAIL mid_full got=%0b/%0b exp=1/0", out_valid, req_ready); end
    #1 resetn = 1'b0;
    #1;
    model_reset();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got=%0b exp=0", out_valid); end
    checks++; if ({A, B, ALUop} !== 67'd0) begin errors++; $display("FAIL mid_data got=%h/%h/%0d exp=0", A, B, ALUop); end
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL mid_ready got=%0b exp=1", req_ready); end
    req_valid = 1'b1; raddr1 = 5'd5; raddr2 = 5'd0; req_aluop = 3'd4;
    tick();
    req_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_after got=%0b exp=1", out_valid); end
`ifdef RF_CLEAR_ON_RESET_EN
    checks++; if (A !== 32'd0) begin errors++; $display("FAIL mid_r5 got=%h exp=0", A); end
`else
    checks++; if (A !== 32'h0000_00FF) begin errors++; $display("FAIL mid_r5 got=%h exp=000000ff", A); end
`endif
    checks++; if (A !== q[0].a) begin errors++; $display("FAIL mid_model got=%h exp=%h", A, q[0].a); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_r0();
    test_bypass();
    test_backpressure();
    test_fill();
    test_streaming();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
